// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main_memory port between instruction fetch and data requesters.
// One access in flight: IDLE -> ACCESS (ack, memory cycle) -> RESP (rvalid), with RESP able to re-arbitrate.
module mem_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_ack,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_err,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_ack,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_err,
  output logic [WIDTH-1:0] mem_raddr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] mem_waddr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_wen
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

  state_e           state_q, state_d;
  logic             last_q, last_d;   // 1 = data was granted last
  logic             sel_q, sel_d;     // 1 = data owns the current access
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic in_range;
  logic pick_d;

  assign in_range = (addr_q < DEPTH_W);
  // On a tie the requester that was not granted last wins.
  assign pick_d   = d_req & (~if_req | ~last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    sel_d     = sel_q;
    we_d      = we_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    if_ack    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    if_err    = 1'b0;
    d_ack     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    d_err     = 1'b0;
    mem_raddr = '0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;

    case (state_q)
      IDLE, RESP: begin
        if (state_q == RESP) begin
          if_rvalid = ~sel_q;
          if_rdata  = sel_q ? '0 : rdata_q;
          if_err    = ~sel_q & err_q;
          d_rvalid  = sel_q;
          d_rdata   = sel_q ? rdata_q : '0;
          d_err     = sel_q & err_q;
        end
        if (if_req | d_req) begin
          state_d = ACCESS;
          sel_d   = pick_d;
          last_d  = pick_d;
          addr_d  = pick_d ? d_addr : if_addr;
          we_d    = pick_d & d_we;
          wdata_d = pick_d ? d_wdata : '0;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if_ack    = ~sel_q;
        d_ack     = sel_q;
        mem_raddr = addr_q;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;
        mem_wen   = we_q & in_range;
        rdata_d   = (in_range & ~we_q) ? mem_rdata : '0;
        err_d     = ~in_range;
        state_d   = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model with shadow memory checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
  localparam int W = 32;
  localparam int D = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [W-1:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic if_ack, if_rvalid, if_err, d_ack, d_rvalid, d_err, mem_wen;
  logic [W-1:0] if_rdata, d_rdata, mem_raddr, mem_rdata, mem_waddr, mem_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wen_cnt = 0;
  int ev_cnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen)
  );

  // main_memory stand-in: combinational read, write on rising edge
  logic [W-1:0] mem [D];
  logic         pl_en = 1'b0;
  logic [10:0]  pl_a = '0;
  logic [W-1:0] pl_d = '0;
  assign mem_rdata = (mem_raddr < D) ? mem[mem_raddr[10:0]] : '0;
  always @(posedge clk) begin
    if (mem_wen) mem[mem_waddr[10:0]] <= mem_wdata;
    if (pl_en) mem[pl_a] <= pl_d;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction model: slot 0 = nothing, 1 = granted (ack cycle), 2 = responding
  logic [W-1:0] sh [D];
  int           slot = 0;
  bit           own = 1'b0;    // 1 = data
  bit           last = 1'b1;
  bit           t_we = 1'b0, t_err = 1'b0;
  logic [W-1:0] t_addr = '0, t_wdata = '0, t_res = '0;
  bit           m_win_d;
  assign m_win_d = (if_req && d_req) ? !last : d_req;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      slot  <= 0;
      last  <= 1'b1;
      own   <= 1'b0;
    end else begin
      if (pl_en) sh[pl_a] <= pl_d;
      if (slot == 1) begin
        t_err <= (t_addr >= D);
        t_res <= (t_addr < D && !t_we) ? sh[t_addr[10:0]] : '0;
        if (t_we && t_addr < D) sh[t_addr[10:0]] <= t_wdata;
        slot <= 2;
      end else if (if_req || d_req) begin
        own     <= m_win_d;
        last    <= m_win_d;
        t_addr  <= m_win_d ? d_addr : if_addr;
        t_we    <= m_win_d && d_we;
        t_wdata <= m_win_d ? d_wdata : '0;
        slot    <= 1;
      end else begin
        slot <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    chk1("if_ack", if_ack, slot == 1 && !own);
    chk1("d_ack", d_ack, slot == 1 && own);
    chk ("mem_raddr", mem_raddr, (slot == 1) ? t_addr : '0);
    chk ("mem_waddr", mem_waddr, (slot == 1) ? t_addr : '0);
    chk ("mem_wdata", mem_wdata, (slot == 1) ? t_wdata : '0);
    chk1("mem_wen", mem_wen, slot == 1 && t_we && t_addr < D);
    chk1("if_rvalid", if_rvalid, slot == 2 && !own);
    chk ("if_rdata", if_rdata, (slot == 2 && !own) ? t_res : '0);
    chk1("if_err", if_err, slot == 2 && !own && t_err);
    chk1("d_rvalid", d_rvalid, slot == 2 && own);
    chk ("d_rdata", d_rdata, (slot == 2 && own) ? t_res : '0);
    chk1("d_err", d_err, slot == 2 && own && t_err);
  end

  always @(negedge clk) begin
    if (mem_wen) wen_cnt <= wen_cnt + 1;
    if (if_ack || d_ack || if_rvalid || d_rvalid) ev_cnt <= ev_cnt + 1;
  end

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic preload(input logic [10:0] a, input logic [W-1:0] v);
    pl_a = a; pl_d = v; pl_en = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Returns right after the edge that raises if_ack (the ack cycle).
  task automatic do_f(input logic [W-1:0] a, output int ackc, output int setc);
    if_req = 1'b1; if_addr = a; setc = cyc; ackc = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (if_ack) begin ackc = cyc; break; end
    end
    if_req = 1'b0;
    if (ackc < 0) begin
      checks++; errors++;
      $display("FAIL fetch_ack_timeout: no if_ack within 20 cycles, required one");
    end
  endtask

  task automatic do_d(input logic we, input logic [W-1:0] a, input logic [W-1:0] wd,
                      output int ackc, output int setc);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; setc = cyc; ackc = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (d_ack) begin ackc = cyc; break; end
    end
    d_req = 1'b0;
    if (ackc < 0) begin
      checks++; errors++;
      $display("FAIL data_ack_timeout: no d_ack within 20 cycles, required one");
    end
  endtask

  int a1, a2, s1, s2, w0, e0;
  int fa[4], fs[4], da[4], ds[4];

  initial begin
    reset_dut();
    chk1("reset_if_ack", if_ack, 1'b0);
    chk1("reset_d_rvalid", d_rvalid, 1'b0);
    chk1("reset_mem_wen", mem_wen, 1'b0);
    chk ("reset_mem_raddr", mem_raddr, '0);
    preload(11'd5, 32'hDEAD);
    preload(11'd0, 32'hA5A5_0000);
    preload(11'd9, 32'h0000_0909);

    // 1: fetch latency and data
    do_f(32'd5, a1, s1);
    chk("t1_ack_latency", a1, s1 + 1);
    @(posedge clk); #1;
    chk ("t1_rvalid_cycle", cyc, s1 + 2);
    chk1("t1_rvalid", if_rvalid, 1'b1);
    chk ("t1_rdata", if_rdata, 32'hDEAD);
    chk1("t1_err", if_err, 1'b0);

    // 2: store then load same address
    w0 = wen_cnt;
    do_d(1'b1, 32'd7, 32'h1234, a1, s1);
    @(posedge clk); #1;
    chk1("t2_store_rvalid", d_rvalid, 1'b1);
    chk ("t2_store_rdata", d_rdata, 32'h0);
    do_d(1'b0, 32'd7, 32'h0, a1, s1);
    @(posedge clk); #1;
    chk1("t2_load_rvalid", d_rvalid, 1'b1);
    chk ("t2_load_rdata", d_rdata, 32'h1234);
    chk ("t2_wen_pulses", wen_cnt - w0, 1);

    // 3: both requesters continuously busy; fetch wins first after reset
    reset_dut();
    fork
      begin
        for (int i = 0; i < 4; i++) do_f(32'd100 + i, fa[i], fs[i]);
      end
      begin
        for (int j = 0; j < 4; j++) do_d(1'b0, 32'd200 + j, 32'h0, da[j], ds[j]);
      end
    join
    for (int i = 0; i < 4; i++) begin
      chk("t3_d_after_f", da[i], fa[i] + 2);
      if (i < 3) chk("t3_f_after_d", fa[i+1], da[i] + 2);
      chk1("t3_f_wait_le4", (fa[i] - fs[i]) <= 4, 1'b1);
      chk1("t3_d_wait_le4", (da[i] - ds[i]) <= 4, 1'b1);
    end
    @(posedge clk); #1;

    // 4: out-of-range store, then in-range load at address 0
    w0 = wen_cnt;
    do_d(1'b1, 32'd2048, 32'hBEEF, a1, s1);
    @(posedge clk); #1;
    chk1("t4_oor_rvalid", d_rvalid, 1'b1);
    chk1("t4_oor_err", d_err, 1'b1);
    chk ("t4_oor_rdata", d_rdata, 32'h0);
    do_d(1'b0, 32'd0, 32'h0, a1, s1);
    @(posedge clk); #1;
    chk1("t4_next_err", d_err, 1'b0);
    chk ("t4_next_rdata", d_rdata, 32'hA5A5_0000);
    chk ("t4_no_wen", wen_cnt - w0, 0);

    // 5: async reset in the middle of a store's access cycle
    @(posedge clk); #1;
    do_d(1'b1, 32'd9, 32'h5555, a1, s1);
    chk1("t5_wen_before_rst", mem_wen, 1'b1);
    #2 rst = 1'b1;
    #1 chk1("t5_wen_dropped", mem_wen, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_mem_unchanged", mem[9], 32'h0000_0909);
    e0 = ev_cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_events_after_release", ev_cnt - e0, 0);
    chk1("t5_d_rvalid", d_rvalid, 1'b0);

    // 6: back-to-back fetches, second ack two cycles after the first
    do_f(32'd5, a1, s1);
    do_f(32'd6, a2, s2);
    chk("t6_b2b_spacing", a2 - a1, 2);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
